// File: rtl/isq_pkg.sv
// Shared sizing and FSM encoding for the age-ordered issue-queue scheduler.
package isq_pkg;

    localparam int ISQ_DEPTH       = 8;
    localparam int ISQ_INDEX_WIDTH = $clog2(ISQ_DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } isq_state_t;

endpackage

// File: rtl/isq_oldest_select.sv
// Combinational oldest-candidate picker: grants the candidate that no other candidate is older than.
module isq_oldest_select #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            candidates,
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
    output logic [DEPTH-1:0]            grant,
    output logic [IDX_W-1:0]            index,
    output logic                        any
);

    logic [DEPTH-1:0] blocked;

    // blocked[i] is set when some other candidate j satisfies age[j][i]
    always_comb begin
        blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                blocked[i] = blocked[i] | (candidates[j] & age[j][i]);
            end
        end
    end

    assign grant = candidates & ~blocked;
    assign any   = |candidates;

    always_comb begin
        index = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/isq_age_scheduler.sv
// Issue-queue scheduler: lowest-free allocation, age-matrix ordering, one issue offer per cycle.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no offer outstanding; latch oldest candidate when one appears
//   ST_OFFER | issue_index offered to the functional unit until accepted
module isq_age_scheduler #(
    parameter int ISQ_DEPTH       = isq_pkg::ISQ_DEPTH,
    parameter int ISQ_INDEX_WIDTH = $clog2(ISQ_DEPTH)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    output logic [ISQ_DEPTH-1:0]       enq_wr_en,
    output logic [ISQ_INDEX_WIDTH-1:0] enq_index,
    input  logic [ISQ_DEPTH-1:0]       entry_valid,
    input  logic [ISQ_DEPTH-1:0]       entry_ready,
    output logic [ISQ_DEPTH-1:0]       entry_clear,
    output logic                       issue_valid,
    output logic [ISQ_INDEX_WIDTH-1:0] issue_index,
    input  logic                       issue_ready,
    output logic [ISQ_INDEX_WIDTH:0]   occupancy,
    output logic                       full,
    output logic                       empty
);

    import isq_pkg::*;

    localparam int D = ISQ_DEPTH;
    localparam int W = ISQ_INDEX_WIDTH;

    isq_state_t            state, state_next;
    logic [W-1:0]          issue_idx_q, issue_idx_next;
    logic [D-1:0]          busy, busy_next;
    logic [D-1:0][D-1:0]   age, age_next;

    logic [W-1:0]          alloc_idx;
    logic                  alloc_found;
    logic                  enq_fire;
    logic                  offering;
    logic [D-1:0]          offer_onehot;
    logic [D-1:0]          candidates;
    logic [D-1:0]          sel_grant;
    logic [W-1:0]          sel_index;
    logic                  sel_any;
    logic                  issue_fire;
    logic [D-1:0]          freed;

    // occupancy and status
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < D; i++) begin
            occupancy = occupancy + (W+1)'(busy[i]);
        end
    end

    assign full      = (occupancy == (W+1)'(D));
    assign empty     = (occupancy == '0);
    assign enq_ready = ~full & ~flush;

    // lowest-index free entry; freed-this-cycle entries still look busy here
    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (!busy[i] && !alloc_found) begin
                alloc_idx   = W'(i);
                alloc_found = 1'b1;
            end
        end
    end

    assign enq_fire  = enq_valid & enq_ready & ~reset;
    assign enq_wr_en = enq_fire ? (D'(1) << alloc_idx) : '0;
    assign enq_index = alloc_idx;

    assign offering     = (state == ST_OFFER);
    assign offer_onehot = D'(1) << issue_idx_q;
    assign candidates   = busy & entry_valid & entry_ready & ~(offering ? offer_onehot : '0);

    isq_oldest_select #(
        .DEPTH (D),
        .IDX_W (W)
    ) u_oldest_select (
        .candidates (candidates),
        .age        (age),
        .grant      (sel_grant),
        .index      (sel_index),
        .any        (sel_any)
    );

    assign issue_fire = offering & issue_ready & ~flush & ~reset;
    assign freed      = issue_fire ? offer_onehot : '0;

    // FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            issue_idx_q <= '0;
        end else begin
            state       <= state_next;
            issue_idx_q <= issue_idx_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next     = state;
        issue_idx_next = issue_idx_q;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_any) begin
                        state_next     = ST_OFFER;
                        issue_idx_next = sel_index;
                    end
                end
                ST_OFFER: begin
                    if (issue_ready) begin
                        if (sel_any) begin
                            issue_idx_next = sel_index;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        issue_valid = offering & ~flush & ~reset;
        issue_index = issue_idx_q;
        entry_clear = freed;
        if (flush && !reset) entry_clear = '1;
    end

    // busy vector and age matrix
    always_comb begin
        busy_next = (busy & ~freed) | enq_wr_en;
        age_next  = age;
        if (enq_fire) begin
            for (int j = 0; j < D; j++) begin
                age_next[alloc_idx][j] = 1'b0;
            end
            for (int j = 0; j < D; j++) begin
                age_next[j][alloc_idx] = busy[j] & ~freed[j];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= '0;
            age  <= '0;
        end else if (flush) begin
            busy <= '0;
            age  <= '0;
        end else begin
            busy <= busy_next;
            age  <= age_next;
        end
    end

endmodule
